// File: rtl/reg2mem_arbiter_if.sv
// Requester handshake, completion and datapath signals of the reg2mem arbiter.
// The slave modport is the arbiter side; the master modport is the requesters/datapath side.
interface reg2mem_arbiter_if;
  logic       req0;
  logic       req1;
  logic [9:0] instr0;
  logic [9:0] instr1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [3:0] rdata;
  logic [9:0] dp_instr;
  logic [3:0] dp_res;
  logic       busy;

  modport slave (
    input  req0, req1, instr0, instr1, dp_res,
    output gnt0, gnt1, done0, done1, rdata, dp_instr, busy
  );

  modport master (
    output req0, req1, instr0, instr1, dp_res,
    input  gnt0, gnt1, done0, done1, rdata, dp_instr, busy
  );
endinterface

// File: rtl/reg2mem_arbiter.sv
// Two-requester arbiter for the reg2mem datapath: grants one instruction at a time,
// holds it for HOLD_CYCLES clocks, then returns the datapath result with a done pulse.
//
// state | meaning
// IDLE  | no transaction; dp_instr keeps the last granted instruction
// EXEC  | instruction held on dp_instr while cnt counts down to 0
// DONE  | one-cycle done pulse, rdata holds the captured result
module reg2mem_arbiter #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  reg2mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_M1  = 4'(HOLD_CYCLES - 1);
  localparam logic [9:0] DP_RESET = 10'b11_0000_0000;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;
  logic       win_q, win_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [3:0] rdata_q, rdata_d;
  logic [9:0] dp_instr_q, dp_instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      prio_q     <= 1'b0;
      win_q      <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      dp_instr_q <= DP_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      dp_instr_q <= dp_instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    win_d      = win_q;
    gnt_d      = '0;
    done_d     = '0;
    rdata_d    = rdata_q;
    dp_instr_d = dp_instr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Ties go to the requester named by prio; a lone request always wins.
          win_d      = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          dp_instr_d = win_d ? bus.instr1 : bus.instr0;
          gnt_d      = win_d ? 2'b10 : 2'b01;
          cnt_d      = HOLD_M1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          rdata_d = bus.dp_res;
          done_d  = win_q ? 2'b10 : 2'b01;
          prio_d  = ~win_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.done0    = done_q[0];
  assign bus.done1    = done_q[1];
  assign bus.rdata    = rdata_q;
  assign bus.dp_instr = dp_instr_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg2mem_arbiter.sv
// Bench for reg2mem_arbiter: three builds (HOLD_CYCLES 2, 1, 15) share one stimulus and are
// checked every cycle against a transaction-timeline model, plus vector table and corner sequences.
module tb_reg2mem_arbiter;

  localparam logic [9:0] I_ST = 10'b00_1010_0101;
  localparam logic [9:0] I_LD = 10'b11_0000_0101;
  localparam logic [9:0] I_MF = 10'b10_0100_0101;
  localparam logic [9:0] I_MT = 10'b01_0100_1011;
  localparam logic [9:0] I_LD11 = 10'b11_0000_1011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_s = 1'b0, req1_s = 1'b0;
  logic [9:0] instr0_s = '0, instr1_s = '0;
  logic [3:0] dp_res_s = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg2mem_arbiter_if bus_h2 ();
  reg2mem_arbiter_if bus_h1 ();
  reg2mem_arbiter_if bus_h15 ();

  assign bus_h2.req0 = req0_s;    assign bus_h2.req1 = req1_s;
  assign bus_h2.instr0 = instr0_s; assign bus_h2.instr1 = instr1_s;
  assign bus_h2.dp_res = dp_res_s;
  assign bus_h1.req0 = req0_s;    assign bus_h1.req1 = req1_s;
  assign bus_h1.instr0 = instr0_s; assign bus_h1.instr1 = instr1_s;
  assign bus_h1.dp_res = dp_res_s;
  assign bus_h15.req0 = req0_s;   assign bus_h15.req1 = req1_s;
  assign bus_h15.instr0 = instr0_s; assign bus_h15.instr1 = instr1_s;
  assign bus_h15.dp_res = dp_res_s;

  reg2mem_arbiter #(.HOLD_CYCLES(2))  dut_h2  (.clk(clk), .rst_n(rst_n), .bus(bus_h2));
  reg2mem_arbiter #(.HOLD_CYCLES(1))  dut_h1  (.clk(clk), .rst_n(rst_n), .bus(bus_h1));
  reg2mem_arbiter #(.HOLD_CYCLES(15)) dut_h15 (.clk(clk), .rst_n(rst_n), .bus(bus_h15));

  // Reference model: each build is described by the edge of its last grant; every output
  // follows from how far the current edge lies from that grant.
  int         hold [3] = '{2, 1, 15};
  int         n_edge = 0;
  int         g_edge [3];
  bit         win [3];
  bit         prio [3];
  logic [9:0] m_dp [3];
  logic [3:0] m_rd [3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      g_edge[k] = -100;
      win[k]    = 1'b0;
      prio[k]   = 1'b0;
      m_dp[k]   = 10'b11_0000_0000;
      m_rd[k]   = 4'd0;
    end
  endfunction

  function automatic void model_edge();
    n_edge++;
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      if (n_edge == g_edge[k] + hold[k]) begin
        m_rd[k] = dp_res_s;
        prio[k] = !win[k];
      end
      if (n_edge >= g_edge[k] + hold[k] + 2 && (req0_s || req1_s)) begin
        win[k]    = (req0_s && req1_s) ? prio[k] : req1_s;
        g_edge[k] = n_edge;
        m_dp[k]   = win[k] ? instr1_s : instr0_s;
      end
    end
  endfunction

  function automatic logic [18:0] exp_out(int k);
    bit g, d, b;
    g = (n_edge == g_edge[k]);
    d = (n_edge == g_edge[k] + hold[k]);
    b = (n_edge >= g_edge[k]) && (n_edge <= g_edge[k] + hold[k]);
    return {g && !win[k], g && win[k], d && !win[k], d && win[k], m_rd[k], m_dp[k], b};
  endfunction

  function automatic logic [18:0] get_out(int k);
    case (k)
      0: return {bus_h2.gnt0, bus_h2.gnt1, bus_h2.done0, bus_h2.done1,
                 bus_h2.rdata, bus_h2.dp_instr, bus_h2.busy};
      1: return {bus_h1.gnt0, bus_h1.gnt1, bus_h1.done0, bus_h1.done1,
                 bus_h1.rdata, bus_h1.dp_instr, bus_h1.busy};
      default: return {bus_h15.gnt0, bus_h15.gnt1, bus_h15.done0, bus_h15.done1,
                       bus_h15.rdata, bus_h15.dp_instr, bus_h15.busy};
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [18:0] o;
    for (int k = 0; k < 3; k++)
      check($sformatf("model_h%0d edge%0d", hold[k], n_edge), get_out(k), exp_out(k));
    o = get_out(0);
    check("exclusive_pulses", {o[18] & o[17], o[16] & o[15], (o[18] | o[17]) & (o[16] | o[15])}, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic apply_reset(int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  // Tiny datapath used only for the chained-transfer sequence.
  logic [3:0] dmem [16];
  logic [3:0] dreg [16];

  function automatic logic [3:0] dp_eval(logic [9:0] ins);
    logic [3:0] res;
    res = 4'd0;
    case (ins[9:8])
      2'b00: dmem[ins[3:0]] = ins[7:4];
      2'b01: dmem[ins[3:0]] = dreg[ins[7:4]];
      2'b10: dreg[ins[7:4]] = dmem[ins[3:0]];
      default: res = dmem[ins[3:0]];
    endcase
    return res;
  endfunction

  typedef struct {
    logic       r0, r1;
    logic [9:0] i0, i1;
    logic [3:0] res;
    logic       g0, g1, d0, d1, b;
    logic [9:0] dp;
    logic [3:0] rd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic r1, logic [9:0] i0, logic [9:0] i1, logic [3:0] res,
                              logic g0, logic g1, logic d0, logic d1, logic b,
                              logic [9:0] dp, logic [3:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.i0 = i0; v.i1 = i1; v.res = res;
    v.g0 = g0; v.g1 = g1; v.d0 = d0; v.d1 = d1; v.b = b; v.dp = dp; v.rd = rd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [13];
    int   t;
    bit   gnt0_seen;
    logic [3:0] exp_res;
    logic [9:0] chain [4];

    // Store then load on requester 0, then a tie resolved towards requester 1.
    tbl[0]  = mk(1, 0, I_ST, 0,    0,  1, 0, 0, 0, 1, I_ST, 0);
    tbl[1]  = mk(0, 0, I_ST, 0,    3,  0, 0, 0, 0, 1, I_ST, 0);
    tbl[2]  = mk(0, 0, I_ST, 0,    7,  0, 0, 1, 0, 1, I_ST, 7);
    tbl[3]  = mk(0, 0, I_ST, 0,    0,  0, 0, 0, 0, 0, I_ST, 7);
    tbl[4]  = mk(1, 0, I_LD, 0,    0,  1, 0, 0, 0, 1, I_LD, 7);
    tbl[5]  = mk(0, 0, I_LD, 0,    10, 0, 0, 0, 0, 1, I_LD, 7);
    tbl[6]  = mk(0, 0, I_LD, 0,    10, 0, 0, 1, 0, 1, I_LD, 10);
    tbl[7]  = mk(0, 0, I_LD, 0,    0,  0, 0, 0, 0, 0, I_LD, 10);
    tbl[8]  = mk(1, 1, I_MT, I_MF, 0,  0, 1, 0, 0, 1, I_MF, 10);
    tbl[9]  = mk(1, 0, I_MT, I_MF, 5,  0, 0, 0, 0, 1, I_MF, 10);
    tbl[10] = mk(1, 0, I_MT, I_MF, 5,  0, 0, 0, 1, 1, I_MF, 5);
    tbl[11] = mk(1, 0, I_MT, I_MF, 0,  0, 0, 0, 0, 0, I_MF, 5);
    tbl[12] = mk(1, 0, I_MT, I_MF, 0,  1, 0, 0, 0, 1, I_MT, 5);

    #2;
    apply_reset(2);
    check("reset_dp_instr", bus_h2.dp_instr, 10'b11_0000_0000);

    for (int i = 0; i < 13; i++) begin
      req0_s = tbl[i].r0; req1_s = tbl[i].r1;
      instr0_s = tbl[i].i0; instr1_s = tbl[i].i1; dp_res_s = tbl[i].res;
      step();
      check($sformatf("table_row%0d", i), get_out(0),
            {tbl[i].g0, tbl[i].g1, tbl[i].d0, tbl[i].d1, tbl[i].rd, tbl[i].dp, tbl[i].b});
    end

    // Both requesters held high from reset: grants alternate every 4 cycles.
    req0_s = 1; req1_s = 1; instr0_s = I_ST; instr1_s = I_LD; dp_res_s = 0;
    apply_reset(2);
    for (int c = 0; c < 16; c++) begin
      step();
      check($sformatf("alt_gnt_c%0d", c), {bus_h2.gnt0, bus_h2.gnt1}, {(c % 8) == 0, (c % 8) == 4});
      check($sformatf("alt_busy_c%0d", c), bus_h2.busy, (c % 4) != 3);
    end
    req0_s = 0; req1_s = 0;

    // Cancel: one-cycle req1 while requester 0 executes.
    apply_reset(2);
    req0_s = 1; instr0_s = I_ST;
    step();
    req0_s = 0; req1_s = 1; instr1_s = I_LD;
    step();
    req1_s = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("cancel_gnt1_c%0d", c), bus_h2.gnt1, 0);
      check($sformatf("cancel_dp_c%0d", c), bus_h2.dp_instr, I_ST);
    end

    // Reset during EXEC, then req0 still high is granted at the first edge.
    apply_reset(1);
    req0_s = 1; instr0_s = I_LD; dp_res_s = 4'd9;
    step();
    step();
    rst_n = 0;
    model_reset();
    #1;
    check("rst_exec_outputs", get_out(0), {4'b0000, 4'd0, 10'b11_0000_0000, 1'b0});
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rst_exec_nodone_c%0d", c), {bus_h2.done0, bus_h2.done1}, 0);
    end
    rst_n = 1;
    step();
    check("rst_release_gnt0", bus_h2.gnt0, 1);
    req0_s = 0;
    repeat (20) step();

    // Chained transfer on requester 1 through a small datapath.
    apply_reset(1);
    for (int a = 0; a < 16; a++) begin dmem[a] = 0; dreg[a] = 0; end
    chain[0] = I_ST; chain[1] = I_MF; chain[2] = I_MT; chain[3] = I_LD11;
    gnt0_seen = 0;
    for (int s = 0; s < 4; s++) begin
      exp_res = dp_eval(chain[s]);
      dp_res_s = exp_res;
      req1_s = 1; instr1_s = chain[s];
      t = 0;
      do begin step(); t++; gnt0_seen |= bus_h2.gnt0; end while (!bus_h2.gnt1 && t < 10);
      check($sformatf("chain_gnt1_s%0d", s), bus_h2.gnt1, 1);
      req1_s = 0;
      t = 0;
      do begin step(); t++; gnt0_seen |= bus_h2.gnt0; end while (!bus_h2.done1 && t < 10);
      check($sformatf("chain_done1_s%0d", s), bus_h2.done1, 1);
      check($sformatf("chain_rdata_s%0d", s), bus_h2.rdata, exp_res);
    end
    check("chain_final_rdata", bus_h2.rdata, 4'd10);
    check("chain_no_gnt0", gnt0_seen, 0);
    repeat (20) step();

    // Random traffic, occasional resets.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 149) == 0) apply_reset($urandom_range(1, 3));
      req0_s   = ($urandom_range(0, 2) != 0);
      req1_s   = ($urandom_range(0, 2) != 0);
      instr0_s = 10'($urandom);
      instr1_s = 10'($urandom);
      dp_res_s = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
